ins_fetch: RTL and testbench
============================

# ins_fetch

Instruction fetch unit that produces the `ins_flg`/`ins`/`pc` stream consumed by the issue decoder. It owns the fetch PC and reads each 32-bit instruction as four little-endian bytes through a request/grant port on the byte-wide memory controller. It buffers one word and hands it downstream under a stall backpressure. A redirect from the commit/branch logic aborts any in-flight fetch.

## Interface

- `RESET_PC`, default 32'h0: fetch PC after reset.
- `clk_in  in  1`: clock; all state updates on the rising edge.
- `rst_in  in  1`: reset; asynchronous, active-low.
- `rdy_in  in  1`: global ready; low pauses the unit (see Operation).
- `mem_req  out  1`: request for the memory port.
- `mem_gnt  in  1`: grant. Once given, the controller holds it high while `mem_req` is high.
- `mem_a  out  32`: byte address.
- `mem_din  in  8`: read byte, valid the cycle after its address is presented under grant.
- `stall  in  1`: downstream cannot accept an instruction this cycle.
- `jump_flg  in  1`: redirect request.
- `jump_pc  in  32`: redirect target.
- `ins_flg  out  1`: one-cycle pulse; `ins`/`pc` are valid and consumed this cycle.
- `ins  out  32`: instruction word.
- `pc  out  32`: address of `ins`.

## Operation

- Registers:
  - `fpc`: next fetch address.
  - `cnt`: 3-bit byte counter.
  - `buf`: 32-bit word buffer, driven as `ins`.
  - `pc`: address of the buffered word.
  - FSM state.
- FSM states:
  - IDLE: reset state, lasts one cycle, then REQ.
  - REQ: `mem_req`=1, `mem_a`=`fpc`. The edge sampling `mem_gnt`=1 counts as issuing byte 0 → READ with `cnt`=1.
  - READ, `cnt`=c, c in 1..3: `mem_req`=1, `mem_a`=`fpc`+c. Capture `mem_din` into `buf[8(c-1)+7:8(c-1)]`, then `cnt`+1.
  - READ, `cnt`=4: `mem_req`=1, `mem_a`=`fpc`+3. Capture byte 3 into `buf[31:24]`, `pc`<=`fpc` → HOLD.
  - HOLD: `mem_req`=0. `ins_flg` = !`stall` & !`jump_flg` (combinational from state). On a delivering cycle: `fpc`<=`fpc`+4, or the predicted target (see Configuration) → REQ. With `stall` high, stay in HOLD with `buf`/`pc` stable.
- Address arithmetic is 32-bit wrap-around; alignment is not checked.
- `jump_flg`=1 in any state:
  - dominates `stall` and any capture;
  - `fpc`<=`jump_pc`, `cnt`<=0, next state REQ;
  - the buffered or partial word is discarded;
  - `ins_flg`=0 that cycle;
  - `mem_req` follows the current state's rule that cycle and drops at most one cycle later.
- `rdy_in`=0:
  - `ins_flg` and `mem_req` are forced 0.
  - In READ: partial bytes are discarded and the state goes to REQ with the same `fpc`.
  - In all other states every register holds.
  - `jump_flg` is ignored while `rdy_in`=0.
- `mem_gnt` low in REQ: wait indefinitely with `mem_a` stable.
- Reset values (asserted asynchronously):
  - state IDLE, `fpc`=`RESET_PC`, `cnt`=0;
  - `mem_req`=0, `mem_a`=`RESET_PC`;
  - `ins_flg`=0, `ins`=0, `pc`=`RESET_PC`.
- Reset mid-READ abandons the access; the controller sees `mem_req` fall immediately.

## Timing

- Grant sampled at the edge ending cycle G; bytes are captured at the edges ending G+1..G+4.
- HOLD is entered in cycle G+5, so `ins_flg` is high in G+5 if `stall`=0.
- From reset release with `mem_gnt` tied high: REQ in cycle 1, first `ins_flg` in cycle 6.
- Steady-state throughput with no stall: one instruction per 6 cycles (REQ, 4×READ, HOLD).
- `ins`/`pc` are registered; `ins_flg` is combinational from state, `stall` and `jump_flg` only.

## Configuration

- `FETCH_JAL_PREDICT_EN`:
  - Defined: on delivery from HOLD, if `buf[6:0]`=7'b1101111, the next `fpc` is `pc` + sign-extended J-immediate `{buf[31],buf[19:12],buf[20],buf[30:21],1'b0}`. Otherwise `pc`+4.
  - Undefined: next `fpc` is always `pc`+4.
  - The delivered `ins`/`pc` are identical in both builds.

## Test plan

- Reset with `RESET_PC`=0, bytes 13 05 10 00 at addresses 0..3, `mem_gnt`=1 → `mem_a` sequence 0,1,2,3; `ins_flg` in cycle 6 with `ins`=32'h00100513, `pc`=0; next REQ uses `mem_a`=4.
- `stall` high for 3 cycles on HOLD entry → `ins_flg` low throughout, `ins` stable; a single pulse on the first cycle `stall`=0, then REQ at 4.
- `jump_flg`=1, `jump_pc`=32'h100 during READ `cnt`=2 → no `ins_flg` for the old word; the next REQ drives `mem_a`=32'h100; the delivered `pc`=32'h100.
- `mem_gnt` held low 5 cycles in REQ → `mem_req`=1 and `mem_a` stable for 5 cycles; `ins_flg` occurs 5 cycles after the grant edge.
- Word 32'h0080006F at 0 → next fetch address 8 with `FETCH_JAL_PREDICT_EN` defined, 4 without it.
- `rdy_in` low for 2 cycles at READ `cnt`=3 → `mem_req` low while paused; the fetch restarts with `mem_a`=`fpc`; the correct word is still delivered.

Source files
------------

// File: rtl/ins_fetch_if.sv
// Fetch-unit bus: byte-wide memory request/grant port plus the ins/pc stream to the issue decoder.
interface ins_fetch_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;
  logic        stall;
  logic        jump_flg;
  logic [31:0] jump_pc;
  logic        ins_flg;
  logic [31:0] ins;
  logic [31:0] pc;

  modport master (
    output mem_req, mem_a, ins_flg, ins, pc,
    input  mem_gnt, mem_din, stall, jump_flg, jump_pc
  );

  modport slave (
    input  mem_req, mem_a, ins_flg, ins, pc,
    output mem_gnt, mem_din, stall, jump_flg, jump_pc
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch: assembles 32-bit words from four little-endian byte reads and holds one for the decoder.
// Optional JAL target prediction on delivery is enabled by defining FETCH_JAL_PREDICT_EN.
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  ins_fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, READ, HOLD} state_t;

  state_t      state_q;
  logic [31:0] fpc_q;
  logic [31:0] buf_q;
  logic [31:0] pc_q;
  logic [2:0]  cnt_q;
  logic [31:0] fpc_d;
  logic [1:0]  off_d;

  always_comb begin
    fpc_d = pc_q + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
    if (buf_q[6:0] == 7'b1101111)
      fpc_d = pc_q + {{11{buf_q[31]}}, buf_q[31], buf_q[19:12], buf_q[20], buf_q[30:21], 1'b0};
`endif
  end

  // The last READ cycle re-presents byte 3; only its capture matters.
  assign off_d = cnt_q[2] ? 2'd3 : cnt_q[1:0];

  assign bus.mem_req = rdy_in && ((state_q == REQ) || (state_q == READ));
  assign bus.mem_a   = (state_q == READ) ? fpc_q + {30'd0, off_d} : fpc_q;
  assign bus.ins_flg = rdy_in && (state_q == HOLD) && !bus.stall && !bus.jump_flg;
  assign bus.ins     = buf_q;
  assign bus.pc      = pc_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      cnt_q   <= 3'd0;
      buf_q   <= 32'd0;
      pc_q    <= RESET_PC;
    end else if (!rdy_in) begin
      // A paused read cannot trust the controller to keep its place, so restart the word.
      if (state_q == READ) begin
        state_q <= REQ;
        cnt_q   <= 3'd0;
      end
    end else if (bus.jump_flg) begin
      fpc_q   <= bus.jump_pc;
      cnt_q   <= 3'd0;
      state_q <= REQ;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (bus.mem_gnt) begin
            cnt_q   <= 3'd1;
            state_q <= READ;
          end
        end
        READ: begin
          case (cnt_q)
            3'd1: begin
              buf_q[7:0] <= bus.mem_din;
              cnt_q      <= 3'd2;
            end
            3'd2: begin
              buf_q[15:8] <= bus.mem_din;
              cnt_q       <= 3'd3;
            end
            3'd3: begin
              buf_q[23:16] <= bus.mem_din;
              cnt_q        <= 3'd4;
            end
            default: begin
              buf_q[31:24] <= bus.mem_din;
              pc_q         <= fpc_q;
              cnt_q        <= 3'd0;
              state_q      <= HOLD;
            end
          endcase
        end
        HOLD: begin
          if (!bus.stall) begin
            fpc_q   <= fpc_d;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed timing scenarios plus a randomized run against a stream-level model.
module tb_ins_fetch;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  always #5 clk_in = ~clk_in;

  ins_fetch_if bus();

  ins_fetch #(.RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PREDICT = 1'b1;
`else
  localparam bit PREDICT = 1'b0;
`endif

  logic [7:0] mem [0:1023];
  always @(posedge clk_in) bus.mem_din <= mem[bus.mem_a[9:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  function automatic logic [31:0] next_fetch(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] imm;
    if (PREDICT && (w[6:0] == 7'h6f)) begin
      imm = ({24'd0, w[19:12]} << 12) + ({31'd0, w[20]} << 11) + ({22'd0, w[30:21]} << 1);
      if (w[31]) imm = imm - 32'h0010_0000;
      return a + imm;
    end
    return a + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #2;
    cyc++;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
  endtask

  task automatic reset_dut();
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    bus.stall    = 1'b0;
    bus.jump_flg = 1'b0;
    bus.jump_pc  = 32'd0;
    bus.mem_gnt  = 1'b1;
    repeat (2) @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    cyc    = 0;
    #1;
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp_a [1:5];
    exp_a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3};
    {mem[3], mem[2], mem[1], mem[0]} = 32'h0010_0513;
    reset_dut();
    total++;
    if ({bus.mem_req, bus.ins_flg} !== 2'b00) begin
      bad++; $display("FAIL ff_idle cyc=%0d got=%b exp=00", cyc, {bus.mem_req, bus.ins_flg});
    end
    for (int c = 1; c <= 5; c++) begin
      tick(); #1;
      total++;
      if ({bus.mem_req, bus.mem_a} !== {1'b1, exp_a[c]}) begin
        bad++; $display("FAIL ff_addr cyc=%0d got=%b/%h exp=1/%h", cyc, bus.mem_req, bus.mem_a, exp_a[c]);
      end
    end
    tick(); #1;
    total++;
    if ({bus.ins_flg, bus.mem_req, bus.ins, bus.pc} !== {2'b10, 32'h0010_0513, 32'd0}) begin
      bad++; $display("FAIL ff_deliver cyc=%0d got=%b%b/%h/%h exp=10/00100513/0", cyc,
                      bus.ins_flg, bus.mem_req, bus.ins, bus.pc);
    end
    tick(); #1;
    total++;
    if ({bus.mem_req, bus.ins_flg, bus.mem_a} !== {2'b10, 32'd4}) begin
      bad++; $display("FAIL ff_next_req cyc=%0d got=%b%b/%h exp=10/4", cyc, bus.mem_req, bus.ins_flg, bus.mem_a);
    end
  endtask

  task automatic test_reset();
    {mem[3], mem[2], mem[1], mem[0]} = 32'h0010_0513;
    reset_dut();
    for (int c = 1; c <= 8; c++) tick();
    rst_in = 1'b0;
    #1;
    total++;
    if ({bus.mem_req, bus.ins_flg, bus.mem_a, bus.ins, bus.pc} !== {2'b00, 32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL reset_values got=%b%b/%h/%h/%h exp=00/0/0/0", bus.mem_req, bus.ins_flg,
                      bus.mem_a, bus.ins, bus.pc);
    end
    rst_in = 1'b1;
    cyc = 0;
    #1;
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL reset_idle got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_stall();
    {mem[3], mem[2], mem[1], mem[0]} = 32'h0010_0513;
    reset_dut();
    bus.stall = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    for (int c = 6; c <= 8; c++) begin
      tick(); #1;
      total++;
      if ({bus.ins_flg, bus.mem_req, bus.ins} !== {2'b00, 32'h0010_0513}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%b%b/%h exp=00/00100513", cyc, bus.ins_flg, bus.mem_req, bus.ins);
      end
    end
    tick();
    bus.stall = 1'b0;
    #1;
    total++;
    if ({bus.ins_flg, bus.pc, bus.ins} !== {1'b1, 32'd0, 32'h0010_0513}) begin
      bad++; $display("FAIL stall_release cyc=%0d got=%b/%h/%h exp=1/0/00100513", cyc, bus.ins_flg, bus.pc, bus.ins);
    end
    tick(); #1;
    total++;
    if ({bus.ins_flg, bus.mem_req, bus.mem_a} !== {2'b01, 32'd4}) begin
      bad++; $display("FAIL stall_next cyc=%0d got=%b%b/%h exp=01/4", cyc, bus.ins_flg, bus.mem_req, bus.mem_a);
    end
  endtask

  task automatic test_jump();
    reset_dut();
    tick(); tick();
    tick();
    bus.jump_flg = 1'b1;
    bus.jump_pc  = 32'h100;
    #1;
    total++;
    if (bus.ins_flg !== 1'b0) begin
      bad++; $display("FAIL jump_flg_cycle cyc=%0d got=%b exp=0", cyc, bus.ins_flg);
    end
    tick();
    bus.jump_flg = 1'b0;
    #1;
    total++;
    if ({bus.mem_req, bus.mem_a} !== {1'b1, 32'h100}) begin
      bad++; $display("FAIL jump_req cyc=%0d got=%b/%h exp=1/100", cyc, bus.mem_req, bus.mem_a);
    end
    for (int c = 5; c <= 8; c++) begin
      tick(); #1;
      total++;
      if (bus.ins_flg !== 1'b0) begin
        bad++; $display("FAIL jump_no_old cyc=%0d got=%b exp=0", cyc, bus.ins_flg);
      end
    end
    tick(); #1;
    total++;
    if ({bus.ins_flg, bus.pc, bus.ins} !== {1'b1, 32'h100, word_at(32'h100)}) begin
      bad++; $display("FAIL jump_deliver cyc=%0d got=%b/%h/%h exp=1/100/%h", cyc, bus.ins_flg, bus.pc,
                      bus.ins, word_at(32'h100));
    end
  endtask

  task automatic test_gnt_wait();
    reset_dut();
    bus.mem_gnt = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick(); #1;
      total++;
      if ({bus.mem_req, bus.mem_a} !== {1'b1, 32'd0}) begin
        bad++; $display("FAIL gnt_wait cyc=%0d got=%b/%h exp=1/0", cyc, bus.mem_req, bus.mem_a);
      end
    end
    tick();
    bus.mem_gnt = 1'b1;
    for (int c = 7; c <= 10; c++) begin
      tick(); #1;
      total++;
      if (bus.ins_flg !== 1'b0) begin
        bad++; $display("FAIL gnt_early cyc=%0d got=%b exp=0", cyc, bus.ins_flg);
      end
    end
    tick(); #1;
    total++;
    if ({bus.ins_flg, bus.pc, bus.ins} !== {1'b1, 32'd0, word_at(32'd0)}) begin
      bad++; $display("FAIL gnt_deliver cyc=%0d got=%b/%h/%h exp=1/0/%h", cyc, bus.ins_flg, bus.pc,
                      bus.ins, word_at(32'd0));
    end
  endtask

  task automatic test_jal();
    logic [31:0] exp_next;
    {mem[3], mem[2], mem[1], mem[0]} = 32'h0080_006F;
    exp_next = PREDICT ? 32'd8 : 32'd4;
    reset_dut();
    for (int c = 1; c <= 5; c++) tick();
    tick(); #1;
    total++;
    if ({bus.ins_flg, bus.ins, bus.pc} !== {1'b1, 32'h0080_006F, 32'd0}) begin
      bad++; $display("FAIL jal_deliver cyc=%0d got=%b/%h/%h exp=1/0080006f/0", cyc, bus.ins_flg, bus.ins, bus.pc);
    end
    tick(); #1;
    total++;
    if ({bus.mem_req, bus.mem_a} !== {1'b1, exp_next}) begin
      bad++; $display("FAIL jal_next cyc=%0d got=%b/%h exp=1/%h", cyc, bus.mem_req, bus.mem_a, exp_next);
    end
  endtask

  task automatic test_rdy_pause();
    reset_dut();
    tick(); tick(); tick();
    tick();
    rdy_in = 1'b0;
    #1;
    total++;
    if ({bus.mem_req, bus.ins_flg} !== 2'b00) begin
      bad++; $display("FAIL rdy_pause_a cyc=%0d got=%b exp=00", cyc, {bus.mem_req, bus.ins_flg});
    end
    tick(); #1;
    total++;
    if ({bus.mem_req, bus.ins_flg} !== 2'b00) begin
      bad++; $display("FAIL rdy_pause_b cyc=%0d got=%b exp=00", cyc, {bus.mem_req, bus.ins_flg});
    end
    tick();
    rdy_in = 1'b1;
    #1;
    total++;
    if ({bus.mem_req, bus.mem_a} !== {1'b1, 32'd0}) begin
      bad++; $display("FAIL rdy_restart cyc=%0d got=%b/%h exp=1/0", cyc, bus.mem_req, bus.mem_a);
    end
    for (int c = 7; c <= 10; c++) tick();
    #1;
    tick(); #1;
    total++;
    if ({bus.ins_flg, bus.pc, bus.ins} !== {1'b1, 32'd0, word_at(32'd0)}) begin
      bad++; $display("FAIL rdy_deliver cyc=%0d got=%b/%h/%h exp=1/0/%h", cyc, bus.ins_flg, bus.pc,
                      bus.ins, word_at(32'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_fpc;
    logic [31:0] w;
    logic        prev_gnt, prev_req;
    int          delivered;
    fill_mem();
    reset_dut();
    exp_fpc   = 32'd0;
    prev_gnt  = 1'b1;
    prev_req  = 1'b0;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rdy_in       = ($urandom_range(0, 19) != 0);
      bus.stall    = ($urandom_range(0, 2) == 0);
      bus.jump_flg = ($urandom_range(0, 29) == 0);
      bus.jump_pc  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      bus.mem_gnt  = (prev_gnt && prev_req) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (!rdy_in) begin
        total++;
        if ({bus.mem_req, bus.ins_flg} !== 2'b00) begin
          bad++; $display("FAIL rnd_paused cyc=%0d got=%b exp=00", cyc, {bus.mem_req, bus.ins_flg});
        end
      end else if (bus.jump_flg) begin
        total++;
        if (bus.ins_flg !== 1'b0) begin
          bad++; $display("FAIL rnd_jump_flg cyc=%0d got=%b exp=0", cyc, bus.ins_flg);
        end
        exp_fpc = bus.jump_pc;
      end else if (bus.ins_flg === 1'b1) begin
        w = word_at(exp_fpc);
        total++;
        if ({bus.pc, bus.ins} !== {exp_fpc, w}) begin
          bad++; $display("FAIL rnd_deliver cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.pc, bus.ins, exp_fpc, w);
        end
        exp_fpc = next_fetch(exp_fpc, w);
        delivered++;
      end
      prev_gnt = bus.mem_gnt;
      prev_req = bus.mem_req;
    end
    total++;
    if (delivered < 100) begin
      bad++; $display("FAIL rnd_progress got=%0d exp>=100", delivered);
    end
  endtask

  initial begin
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    bus.stall    = 1'b0;
    bus.jump_flg = 1'b0;
    bus.jump_pc  = 32'd0;
    bus.mem_gnt  = 1'b1;
    fill_mem();
    test_first_fetch();
    test_reset();
    test_stall();
    test_jump();
    test_gnt_wait();
    test_jal();
    test_rdy_pause();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
